// File: rtl/truth_table_checker.sv
// Sweeps every input vector onto an external gate, holds each for HOLD_CYCLES,
// and scores the sampled response against a selectable golden gate function.
module truth_table_checker #(
    parameter int unsigned N_IN        = 2,
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned ERR_W       = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [2:0]        mode,
    output logic [N_IN-1:0]   stim,
    input  logic              resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int unsigned    HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [2:0]        mode_q;
    logic [HOLD_W-1:0] hold_cnt;

    logic golden_c;
    logic sample_c;
    logic mismatch_c;
    logic last_vec_c;

    // Golden gate response for the vector currently driven
    always_comb begin
        golden_c = 1'b0;
        case (mode_q)
            3'd0: golden_c = &stim;
            3'd1: golden_c = |stim;
            3'd2: golden_c = ~&stim;
            3'd3: golden_c = ~|stim;
            3'd4: golden_c = ^stim;
            3'd5: golden_c = ~^stim;
            3'd6: golden_c = stim[0];
            3'd7: golden_c = ~stim[0];
            default: golden_c = 1'b0;
        endcase
    end

    always_comb begin
        sample_c   = (state == DRIVE) && (hold_cnt == HOLD_LAST);
        mismatch_c = sample_c && (resp != golden_c);
        last_vec_c = &stim;
    end

    // pass is derived from the first-error flag so a saturated counter cannot mask it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            mode_q          <= '0;
            hold_cnt        <= '0;
            stim            <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= DRIVE;
                        mode_q          <= mode;
                        hold_cnt        <= '0;
                        stim            <= '0;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_vec   <= '0;
                        first_err_valid <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (sample_c) begin
                        hold_cnt <= '0;
                        if (mismatch_c) begin
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (!first_err_valid) begin
                                first_err_vec   <= stim;
                                first_err_valid <= 1'b1;
                            end
                        end
                        if (last_vec_c) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            stim  <= '0;
                            pass  <= !(first_err_valid || mismatch_c);
                        end else begin
                            stim <= stim + N_IN'(1);
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (default parameters and a small
// fast/saturating one) scored against a sweep-timeline model every cycle.
module tb_truth_table_checker;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // Instance A: N_IN=2, HOLD_CYCLES=50, ERR_W=8
    logic       start0 = 1'b0;
    logic [2:0] mode0 = 3'd0;
    logic [1:0] stim0;
    logic       resp0, busy0, done0, pass0, fv0;
    logic [7:0] err0;
    logic [1:0] fev0;

    // Instance B: N_IN=3, HOLD_CYCLES=1, ERR_W=2
    logic       start1 = 1'b0;
    logic [2:0] mode1 = 3'd0;
    logic [2:0] stim1;
    logic       resp1, busy1, done1, pass1, fv1;
    logic [1:0] err1;
    logic [2:0] fev1;

    // Gate-under-test behaviour: kind 0 ideal, 1 stuck-at-1, 2 inverted at one vector, 3 always inverted
    int f_kind [2];
    int f_gt   [2];
    int f_bad  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit cmp_en  = 1'b0;

    function automatic logic gold(input int md, input int v, input int n);
        int ones;
        ones = $countones(v);
        case (md)
            0: return ones == n;
            1: return ones != 0;
            2: return ones != n;
            3: return ones == 0;
            4: return (ones % 2) == 1;
            5: return (ones % 2) == 0;
            6: return (v % 2) == 1;
            default: return (v % 2) == 0;
        endcase
    endfunction

    function automatic logic fresp(input int kind, input int gt, input int bad, input int v, input int n);
        case (kind)
            0: return gold(gt, v, n);
            1: return 1'b1;
            2: return gold(gt, v, n) ^ (v == bad);
            default: return !gold(gt, v, n);
        endcase
    endfunction

    function automatic int p_n(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int p_h(input int i);
        return (i == 0) ? 50 : 1;
    endfunction

    function automatic int p_emax(input int i);
        return (i == 0) ? 255 : 3;
    endfunction

    assign resp0 = fresp(f_kind[0], f_gt[0], f_bad[0], int'(stim0), 2);
    assign resp1 = fresp(f_kind[1], f_gt[1], f_bad[1], int'(stim1), 3);

    truth_table_checker u_a (
        .clk(clk), .reset_n(reset_n), .start(start0), .mode(mode0), .stim(stim0),
        .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_vec(fev0), .first_err_valid(fv0)
    );

    truth_table_checker #(.N_IN(3), .HOLD_CYCLES(1), .ERR_W(2)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start1), .mode(mode1), .stim(stim1),
        .resp(resp1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_err_vec(fev1), .first_err_valid(fv1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Sweep timeline model: a sweep accepted at edge e0 drives vector (t/H) and
    // scores vector k at t = (k+1)*H; the final score ends the sweep.
    bit m_active [2];
    bit m_done   [2];
    bit m_pass   [2];
    bit m_fv     [2];
    int m_fvec   [2];
    int m_true   [2];
    int m_e0     [2];
    int m_mode   [2];

    always @(posedge clk or negedge reset_n) begin
        bit idle;
        bit st;
        int t;
        int k;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0; m_fv[i] = 1'b0;
                m_fvec[i] = 0; m_true[i] = 0; m_e0[i] = 0; m_mode[i] = 0;
            end
        end else begin
            cyc = cyc + 1;
            for (int i = 0; i < 2; i++) begin
                idle = !m_active[i] && !m_done[i];
                st   = (i == 0) ? start0 : start1;
                m_done[i] = 1'b0;
                if (m_active[i]) begin
                    t = cyc - m_e0[i];
                    if (t % p_h(i) == 0) begin
                        k = t / p_h(i) - 1;
                        if (fresp(f_kind[i], f_gt[i], f_bad[i], k, p_n(i)) != gold(m_mode[i], k, p_n(i))) begin
                            m_true[i] = m_true[i] + 1;
                            if (!m_fv[i]) begin
                                m_fv[i]   = 1'b1;
                                m_fvec[i] = k;
                            end
                        end
                        if (k == (1 << p_n(i)) - 1) begin
                            m_active[i] = 1'b0;
                            m_done[i]   = 1'b1;
                            m_pass[i]   = (m_true[i] == 0);
                        end
                    end
                end else if (idle && st) begin
                    m_active[i] = 1'b1;
                    m_e0[i]     = cyc;
                    m_mode[i]   = (i == 0) ? int'(mode0) : int'(mode1);
                    m_true[i]   = 0;
                    m_fv[i]     = 1'b0;
                    m_fvec[i]   = 0;
                    m_pass[i]   = 1'b0;
                end
            end
        end
    end

    task automatic cmp_inst(input int i, input int stim, input logic busy, input logic done,
                            input logic pass, input int err, input int fev, input logic fv);
        int es;
        int ee;
        es = m_active[i] ? (cyc - m_e0[i]) / p_h(i) : 0;
        ee = (m_true[i] > p_emax(i)) ? p_emax(i) : m_true[i];
        chk($sformatf("stim%0d", i),  32'(stim), 32'(es));
        chk($sformatf("busy%0d", i),  32'(busy), 32'(m_active[i]));
        chk($sformatf("done%0d", i),  32'(done), 32'(m_done[i]));
        chk($sformatf("pass%0d", i),  32'(pass), 32'(m_pass[i]));
        chk($sformatf("err%0d", i),   32'(err),  32'(ee));
        chk($sformatf("fvec%0d", i),  32'(fev),  32'(m_fvec[i]));
        chk($sformatf("fval%0d", i),  32'(fv),   32'(m_fv[i]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_inst(0, int'(stim0), busy0, done0, pass0, int'(err0), int'(fev0), fv0);
            cmp_inst(1, int'(stim1), busy1, done1, pass1, int'(err1), int'(fev1), fv1);
        end
    end

    // Pulse start for one cycle and count cycles from the accepting edge to done
    task automatic run_sweep(input int i, input int md, input int budget, output int n);
        n = 0;
        if (i == 0) begin start0 = 1'b1; mode0 = 3'(md); end
        else begin start1 = 1'b1; mode1 = 3'(md); end
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (c == 0) begin start0 = 1'b0; start1 = 1'b0; end
            if (((i == 0) ? done0 : done1) === 1'b1) return;
            n = n + 1;
        end
    endtask

    task automatic wait_done0(input int budget);
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done0 === 1'b1) return;
        end
        chk("done0_timeout", 32'(done0), 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin f_kind[i] = 0; f_gt[i] = 0; f_bad[i] = 0; end
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_stim0", 32'(stim0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_err1",  32'(err1), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ideal NAND, default parameters
        f_kind[0] = 0; f_gt[0] = 2;
        run_sweep(0, 2, 400, n);
        chk("nand_latency", 32'(n), 32'd200);
        chk("nand_pass", 32'(pass0), 1);
        chk("nand_err", 32'(err0), 0);
        chk("nand_fval", 32'(fv0), 0);
        chk("nand_model_pass", 32'(m_pass[0]), 1);
        repeat (2) @(negedge clk);

        // Stuck-at-1 against AND
        f_kind[0] = 1;
        run_sweep(0, 0, 400, n);
        chk("and_sa1_err", 32'(err0), 3);
        chk("and_sa1_fvec", 32'(fev0), 0);
        chk("and_sa1_fval", 32'(fv0), 1);
        chk("and_sa1_pass", 32'(pass0), 0);
        chk("and_sa1_model_err", 32'(m_true[0]), 3);
        repeat (2) @(negedge clk);

        // Single fault at vector 5, XOR, one cycle per vector
        f_kind[1] = 2; f_gt[1] = 4; f_bad[1] = 5;
        run_sweep(1, 4, 40, n);
        chk("xor_latency", 32'(n), 32'd8);
        chk("xor_err", 32'(err1), 1);
        chk("xor_fvec", 32'(fev1), 5);
        chk("xor_pass", 32'(pass1), 0);
        chk("xor_model_fvec", 32'(m_fvec[1]), 5);
        repeat (2) @(negedge clk);

        // Saturating counter, XNOR always wrong
        f_kind[1] = 3; f_gt[1] = 5;
        run_sweep(1, 5, 40, n);
        chk("sat_err", 32'(err1), 3);
        chk("sat_pass", 32'(pass1), 0);
        chk("sat_fvec", 32'(fev1), 0);
        chk("sat_model_true", 32'(m_true[1]), 8);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a sweep
        f_kind[0] = 0; f_gt[0] = 2;
        start0 = 1'b1; mode0 = 3'd2;
        @(negedge clk);
        start0 = 1'b0;
        for (int c = 0; c < 200 && stim0 !== 2'd2; c++) @(negedge clk);
        chk("mid_stim_reached", 32'(stim0), 2);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_stim", 32'(stim0), 0);
        chk("arst_busy", 32'(busy0), 0);
        chk("arst_done", 32'(done0), 0);
        chk("arst_pass", 32'(pass0), 0);
        chk("arst_err", 32'(err0), 0);
        chk("arst_fvec", 32'(fev0), 0);
        chk("arst_fval", 32'(fv0), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_sweep(0, 2, 400, n);
        chk("post_rst_latency", 32'(n), 32'd200);
        chk("post_rst_pass", 32'(pass0), 1);
        repeat (2) @(negedge clk);

        // start held high from mid-sweep through done; mode changed to AND meanwhile
        start0 = 1'b1; mode0 = 3'd2;
        @(negedge clk);
        start0 = 1'b0;
        repeat (74) @(negedge clk);
        start0 = 1'b1; mode0 = 3'd0;
        wait_done0(300);
        chk("busy_first_pass", 32'(pass0), 1);
        chk("busy_first_err", 32'(err0), 0);
        repeat (2) @(negedge clk);
        chk("second_busy", 32'(busy0), 1);
        start0 = 1'b0;
        wait_done0(300);
        chk("second_err", 32'(err0), 4);
        chk("second_pass", 32'(pass0), 0);
        chk("second_fvec", 32'(fev0), 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Parametrised hardware truth-table checker: the synthesizable successor to our per-gate stimulus benches. It sweeps all 2^N_IN input combinations onto an external gate-under-test and holds each vector for a programmable number of cycles. It samples the response and compares it against a built-in golden model for a runtime-selectable gate function, then reports pass/fail, a saturating error count and the first failing vector. It sits beside the gate-under-test on the FPGA fabric, typically driven by a button/switch wrapper.

## Interface
- N_IN, default 2: inputs of the gate-under-test; legal range 1..16.
- HOLD_CYCLES, default 50: cycles each vector is held; legal range ≥1.
- ERR_W, default 8: width of the error counter.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- mode  in  3  gate function; latched at start.
- stim  out  N_IN  vector driven to the gate-under-test.
- resp  in  1  gate-under-test output.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse at end of sweep.
- pass  out  1  result of last sweep; valid from done until next start.
- err_count  out  ERR_W  mismatches in the last sweep, saturating.
- first_err_vec  out  N_IN  stim value of the first mismatch.
- first_err_valid  out  1  first_err_vec holds a captured value.

## Operation
- Golden function of mode, applied to stim:
  - 0 AND
  - 1 OR
  - 2 NAND
  - 3 NOR
  - 4 XOR (odd parity)
  - 5 XNOR
  - 6 BUF stim[0]
  - 7 NOT stim[0]
- Reductions span all N_IN bits.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - busy=0, done=0, stim=0.
  - On start=1 at a rising edge:
    - stim<=0, hold counter<=0, err_count<=0, first_err_valid<=0, first_err_vec<=0, pass<=0;
    - latch mode into mode_q;
    - go to DRIVE.
- DRIVE:
  - busy=1; hold counter increments each cycle.
  - When counter==HOLD_CYCLES-1, resp is sampled and compared with golden(mode_q, stim):
    - On mismatch, err_count increments, saturating at 2^ERR_W-1.
    - If first_err_valid=0, first_err_vec<=stim and first_err_valid<=1.
    - If stim is all ones, go to DONE. Otherwise stim<=stim+1 and counter<=0.
- DONE (one cycle):
  - done=1, busy=0.
  - pass<=(no mismatch occurred); it must reflect a true zero count even if the counter saturated.
  - stim returns to 0; next state IDLE.
- start is ignored while in DRIVE or DONE. A start held high re-triggers only from IDLE.
- Results (pass, err_count, first_err_*) persist in IDLE until the next accepted start.
- Reset (any time, including mid-sweep):
  - state IDLE;
  - all outputs 0 (stim, busy, done, pass, err_count, first_err_vec, first_err_valid).
  - No partial result survives.

## Timing
- Start accepted at edge E0. stim=0 and busy=1 are visible after E0.
- Vector k is driven from edge E0+k·HOLD_CYCLES. resp is sampled at edge E0+(k+1)·HOLD_CYCLES, i.e. after HOLD_CYCLES full cycles of settle.
- done is high for the one cycle following edge E0+2^N_IN·HOLD_CYCLES.
  - Next start is accepted no earlier than the edge after done.
- resp is treated as synchronous to clk. Metastability protection for asynchronous gate outputs is outside this block.
- HOLD_CYCLES=1: a new vector every cycle; each sample sees the vector driven in the previous cycle.
- Counter widths:
  - hold counter: clog2(HOLD_CYCLES) bits, minimum 1.
  - stim: exactly N_IN bits. Wrap is never taken; all ones terminates the sweep.

## Test plan
- Ideal NAND, default parameters (N_IN=2, HOLD_CYCLES=50): bench models resp=~&stim, start with mode=2 -> stim steps 0,1,2,3 every 50 cycles; done 200 cycles after start edge; pass=1, err_count=0, first_err_valid=0.
- Stuck-at-1 output, N_IN=2, mode=0 (AND), resp tied 1 -> err_count=3, first_err_vec=0, first_err_valid=1, pass=0.
- Single fault, N_IN=3, HOLD_CYCLES=1, mode=4 (XOR): resp correct except inverted at stim=5 -> err_count=1, first_err_vec=5, pass=0; done 8 cycles after start.
- Saturation, ERR_W=2, N_IN=3, mode=5: resp always wrong -> err_count=3 (not wrapping), pass=0, first_err_vec=0.
- Reset mid-sweep: assert reset_n=0 at stim=2 of a default run -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh start runs the full 200-cycle sweep.
- Start while busy: pulse start at cycle 75 and hold start high through done -> the first sweep completes unaffected. A second sweep begins on the edge after done. mode is taken from its value at that edge.
